m_cyclecnt_wide: RTL and testbench

Parametrised per-instruction cycle timer for midgetv, generalised from the fixed 6-bit instruction timer. It times each instruction in a CW-bit counter and muxes the count onto ALU input B (QQ) during WAIT1 so it can be accumulated into the 64-bit cycle CSR. It also provides:
- the +3/+4 PC-increment constant path on QQ;
- start qualification for corerunning, with a length independent of the counter width;
- a programmable per-instruction timeout that raises buserror;
- a peak-instruction-length capture register for profiling.

---
 rtl/m_cyclecnt_wide_if.sv | 25 ++
 rtl/m_cyclecnt_wide.sv | 82 ++++++++
 tb/tb_m_cyclecnt_wide.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/m_cyclecnt_wide_if.sv
// Bus between the midgetv microcode/core side and the per-instruction cycle timer.
// The master drives the microcode selects, address and control; the slave returns QQ and status.
interface m_cyclecnt_wide_if #(
  parameter int CW = 6
);
  logic          sa17;
  logic          sa16;
  logic [31:0]   ADR_O;
  logic          start;
  logic          peak_clr;
  logic [31:0]   QQ;
  logic          corerunning;
  logic          buserror;
  logic [CW-1:0] peak;

  modport master (
    output sa17, sa16, ADR_O, start, peak_clr,
    input  QQ, corerunning, buserror, peak
  );

  modport slave (
    input  sa17, sa16, ADR_O, start, peak_clr,
    output QQ, corerunning, buserror, peak
  );
endinterface

// File: rtl/m_cyclecnt_wide.sv
// Per-instruction cycle timer: counts each instruction, feeds the count or a PC constant onto QQ,
// qualifies core release, traps hung instructions and records the longest completed instruction.
module m_cyclecnt_wide #(
  parameter int CW       = 6,
  parameter int STARTLEN = 64,
  parameter int TIMEOUT  = (1 << CW) - 1
) (
  input logic              clk,
  input logic              rst_n,
  m_cyclecnt_wide_if.slave bus
);
  localparam int              SQW         = $clog2(STARTLEN + 1);
  localparam logic [CW-1:0]   CNT_ONE     = CW'(1);
  localparam logic [CW-1:0]   CNT_TIMEOUT = CW'(TIMEOUT);
  localparam logic [CW-1:0]   PC_INC_MASK = CW'(3);
  localparam logic [SQW-1:0]  SQ_ONE      = SQW'(1);
  localparam logic [SQW-1:0]  SQ_MAX      = SQW'(STARTLEN);
  localparam logic [SQW-1:0]  SQ_LAST     = SQW'(STARTLEN - 1);

  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  peak_q, peak_d;
  logic [CW-1:0]  qq_lo;
  logic [SQW-1:0] sq_q, sq_d;
  logic           corerunning_q, corerunning_d;
  logic           notfirst_q;
  logic           timeout_hit;

  // An instruction boundary in the same cycle as the timeout value wins over the trap.
  assign timeout_hit = corerunning_q & bus.start & ~bus.sa16 & (cnt_q == CNT_TIMEOUT);

  always_comb begin
    cnt_d = cnt_q + CNT_ONE;
    if (!bus.start || bus.sa16 || timeout_hit) begin
      cnt_d = CNT_ONE;
    end

    sq_d = sq_q;
    if (!bus.start) begin
      sq_d = '0;
    end else if (sq_q < SQ_MAX) begin
      sq_d = sq_q + SQ_ONE;
    end

    corerunning_d = corerunning_q | (bus.start & (sq_q == SQ_LAST));

    peak_d = peak_q;
    if (bus.peak_clr) begin
      peak_d = '0;
    end else if (bus.sa16 && corerunning_q && (cnt_q > peak_q)) begin
      peak_d = cnt_q;
    end

    // +3/+4 PC increment: ADR_O with its two low bits forced high.
    qq_lo = bus.ADR_O[CW-1:0] | PC_INC_MASK;
    if (bus.sa16) begin
      qq_lo = cnt_q;
    end else if (bus.sa17) begin
      qq_lo = bus.ADR_O[CW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= CNT_ONE;
      sq_q          <= '0;
      corerunning_q <= 1'b0;
      notfirst_q    <= 1'b0;
      peak_q        <= '0;
    end else begin
      cnt_q         <= cnt_d;
      sq_q          <= sq_d;
      corerunning_q <= corerunning_d;
      notfirst_q    <= 1'b1;
      peak_q        <= peak_d;
    end
  end

  assign bus.QQ          = {bus.ADR_O[31:CW], qq_lo};
  assign bus.corerunning = corerunning_q;
  assign bus.buserror    = ~notfirst_q | timeout_hit;
  assign bus.peak        = peak_q;
endmodule

// File: tb/tb_m_cyclecnt_wide.sv
// Directed bench for m_cyclecnt_wide: a CW=6/TIMEOUT=41 instance for release, QQ and timeout
// behaviour, and a CW=12/TIMEOUT=4000 instance for long-instruction peak capture.
module tb_m_cyclecnt_wide;
  logic clk = 1'b0;
  logic rst_n_a;
  logic rst_n_b;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  m_cyclecnt_wide_if #(.CW(6))  bus_a ();
  m_cyclecnt_wide_if #(.CW(12)) bus_b ();

  m_cyclecnt_wide #(.CW(6), .STARTLEN(64), .TIMEOUT(41)) dut_a (
    .clk   (clk),
    .rst_n (rst_n_a),
    .bus   (bus_a.slave)
  );

  m_cyclecnt_wide #(.CW(12), .STARTLEN(4), .TIMEOUT(4000)) dut_b (
    .clk   (clk),
    .rst_n (rst_n_b),
    .bus   (bus_b.slave)
  );

  task automatic test_reset();
    rst_n_a = 1'b0;
    bus_a.start = 1'b1; bus_a.sa16 = 1'b0; bus_a.sa17 = 1'b0;
    bus_a.peak_clr = 1'b0; bus_a.ADR_O = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if (bus_a.corerunning !== 1'b0) begin tests_failed++; $display("FAIL reset_corerunning: got %b want 0", bus_a.corerunning); end
    tests_run++;
    if (bus_a.peak !== 6'd0) begin tests_failed++; $display("FAIL reset_peak: got %0d want 0", bus_a.peak); end
    @(negedge clk);
    rst_n_a = 1'b1;
    #1;
    tests_run++;
    if (bus_a.buserror !== 1'b1) begin tests_failed++; $display("FAIL first_cycle_buserror: got %b want 1", bus_a.buserror); end
    tests_run++;
    if (bus_a.QQ !== 32'h3) begin tests_failed++; $display("FAIL first_cycle_qq: got %h want 00000003", bus_a.QQ); end
    for (int k = 2; k <= 70; k++) begin
      @(negedge clk); #1;
      tests_run++;
      if (bus_a.corerunning !== (k >= 65)) begin
        tests_failed++; $display("FAIL release_cycle%0d: corerunning got %b want %b", k, bus_a.corerunning, (k >= 65));
      end
      tests_run++;
      if (bus_a.buserror !== 1'b0) begin
        tests_failed++; $display("FAIL buserror_cycle%0d: got %b want 0", k, bus_a.buserror);
      end
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_sa16_pulse();
    // Sync boundary together with peak_clr so the stray count from before is discarded.
    @(negedge clk);
    bus_a.sa16 = 1'b1; bus_a.peak_clr = 1'b1; bus_a.ADR_O = 32'h1234_5670; bus_a.sa17 = 1'b0;
    @(negedge clk);
    bus_a.sa16 = 1'b0; bus_a.peak_clr = 1'b0;
    #1;
    tests_run++;
    if (bus_a.peak !== 6'd0) begin tests_failed++; $display("FAIL peak_clr_sync: got %0d want 0", bus_a.peak); end
    for (int p = 0; p < 3; p++) begin
      for (int j = 2; j <= 4; j++) begin
        @(negedge clk); #1;
        tests_run++;
        if (bus_a.QQ !== 32'h1234_5673) begin
          tests_failed++; $display("FAIL qq_pcinc p%0d j%0d: got %h want 12345673", p, j, bus_a.QQ);
        end
      end
      @(negedge clk);
      bus_a.sa16 = 1'b1;
      #1;
      tests_run++;
      if (bus_a.QQ !== 32'h1234_5645) begin
        tests_failed++; $display("FAIL qq_cnt p%0d: got %h want 12345645", p, bus_a.QQ);
      end
      @(negedge clk);
      bus_a.sa16 = 1'b0;
      #1;
      tests_run++;
      if (bus_a.peak !== 6'd5) begin
        tests_failed++; $display("FAIL peak_after_pulse p%0d: got %0d want 5", p, bus_a.peak);
      end
      $display("[TB] sa16 pulse %0d checked", p);
    end
  endtask

  task automatic test_timeout();
    // Entered in the cycle where cnt is 1; the count climbs to 41 undisturbed.
    for (int j = 2; j <= 45; j++) begin
      @(negedge clk);
      bus_a.sa17 = (j == 10);
      #1;
      tests_run++;
      if (bus_a.buserror !== (j == 41)) begin
        tests_failed++; $display("FAIL timeout_cycle%0d: buserror got %b want %b", j, bus_a.buserror, (j == 41));
      end
      if (j == 10) begin
        tests_run++;
        if (bus_a.QQ !== 32'h1234_5670) begin
          tests_failed++; $display("FAIL qq_sa17: got %h want 12345670", bus_a.QQ);
        end
      end
      if (j == 45) begin
        tests_run++;
        if (bus_a.peak !== 6'd5) begin
          tests_failed++; $display("FAIL peak_after_timeout: got %0d want 5", bus_a.peak);
        end
      end
    end
    @(negedge clk);
    bus_a.sa17 = 1'b0; bus_a.sa16 = 1'b1;
    #1;
    tests_run++;
    if (bus_a.QQ[5:0] !== 6'd5) begin
      tests_failed++; $display("FAIL cnt_after_timeout: got %0d want 5", bus_a.QQ[5:0]);
    end
    @(negedge clk);
    bus_a.sa16 = 1'b0;
    $display("[TB] test_timeout done");
  endtask

  task automatic test_boundary_at_timeout();
    // Entered in a cnt==1 cycle; boundary arrives exactly when cnt reaches 41.
    for (int j = 2; j <= 41; j++) begin
      @(negedge clk);
      bus_a.sa16 = (j == 41);
      #1;
      if (j == 41) begin
        tests_run++;
        if (bus_a.buserror !== 1'b0) begin
          tests_failed++; $display("FAIL boundary_buserror: got %b want 0", bus_a.buserror);
        end
        tests_run++;
        if (bus_a.QQ[5:0] !== 6'd41) begin
          tests_failed++; $display("FAIL boundary_cnt: got %0d want 41", bus_a.QQ[5:0]);
        end
      end
    end
    @(negedge clk);
    bus_a.sa16 = 1'b0;
    #1;
    tests_run++;
    if (bus_a.peak !== 6'd41) begin
      tests_failed++; $display("FAIL boundary_peak: got %0d want 41", bus_a.peak);
    end
    $display("[TB] test_boundary_at_timeout done");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus_a.sa16 = 1'b1;
    #1;
    tests_run++;
    if (bus_a.QQ[5:0] !== 6'd2) begin
      tests_failed++; $display("FAIL b2b_first: got %0d want 2", bus_a.QQ[5:0]);
    end
    @(negedge clk); #1;
    tests_run++;
    if (bus_a.QQ[5:0] !== 6'd1) begin
      tests_failed++; $display("FAIL b2b_reload: got %0d want 1", bus_a.QQ[5:0]);
    end
    @(negedge clk);
    bus_a.sa16 = 1'b0;
    #1;
    tests_run++;
    if (bus_a.peak !== 6'd41) begin
      tests_failed++; $display("FAIL b2b_peak: got %0d want 41", bus_a.peak);
    end
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_requalify();
    @(negedge clk);
    #2;
    rst_n_a = 1'b0;
    #1;
    tests_run++;
    if (bus_a.corerunning !== 1'b0) begin
      tests_failed++; $display("FAIL async_reset_corerunning: got %b want 0", bus_a.corerunning);
    end
    tests_run++;
    if (bus_a.peak !== 6'd0) begin
      tests_failed++; $display("FAIL async_reset_peak: got %0d want 0", bus_a.peak);
    end
    @(negedge clk);
    rst_n_a = 1'b1; bus_a.start = 1'b1;
    #1;
    tests_run++;
    if (bus_a.buserror !== 1'b1) begin
      tests_failed++; $display("FAIL rerelease_buserror: got %b want 1", bus_a.buserror);
    end
    for (int k = 2; k <= 110; k++) begin
      @(negedge clk);
      bus_a.start = (k != 41);
      #1;
      tests_run++;
      if (bus_a.corerunning !== (k >= 106)) begin
        tests_failed++; $display("FAIL requalify_cycle%0d: corerunning got %b want %b", k, bus_a.corerunning, (k >= 106));
      end
    end
    $display("[TB] test_requalify done");
  endtask

  task automatic test_peak_wide();
    int lens [3];
    int exp_peak [3];
    lens = '{100, 3000, 50};
    exp_peak = '{100, 3000, 3000};
    rst_n_b = 1'b0;
    bus_b.start = 1'b1; bus_b.sa16 = 1'b0; bus_b.sa17 = 1'b0;
    bus_b.peak_clr = 1'b0; bus_b.ADR_O = 32'h0;
    repeat (2) @(negedge clk);
    rst_n_b = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      tests_run++;
      if (bus_b.corerunning !== (k >= 5)) begin
        tests_failed++; $display("FAIL wide_release_cycle%0d: got %b want %b", k, bus_b.corerunning, (k >= 5));
      end
    end
    @(negedge clk);
    bus_b.sa16 = 1'b1; bus_b.peak_clr = 1'b1;
    @(negedge clk);
    bus_b.sa16 = 1'b0; bus_b.peak_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 2; j <= lens[i]; j++) begin
        @(negedge clk);
        bus_b.sa16 = (j == lens[i]);
        #1;
        if (j == lens[i]) begin
          tests_run++;
          if (bus_b.QQ !== 32'(lens[i])) begin
            tests_failed++; $display("FAIL wide_len%0d: QQ got %0d want %0d", i, bus_b.QQ, lens[i]);
          end
        end
      end
      @(negedge clk);
      bus_b.sa16 = 1'b0;
      #1;
      tests_run++;
      if (bus_b.peak !== 12'(exp_peak[i])) begin
        tests_failed++; $display("FAIL wide_peak%0d: got %0d want %0d", i, bus_b.peak, exp_peak[i]);
      end
      $display("[TB] wide instruction %0d length %0d peak %0d", i, lens[i], bus_b.peak);
    end
    for (int j = 2; j <= 10; j++) begin
      @(negedge clk);
      bus_b.sa16 = (j == 10);
      bus_b.peak_clr = (j == 10);
    end
    @(negedge clk);
    bus_b.sa16 = 1'b0; bus_b.peak_clr = 1'b0;
    #1;
    tests_run++;
    if (bus_b.peak !== 12'd0) begin
      tests_failed++; $display("FAIL wide_peak_clr: got %0d want 0", bus_b.peak);
    end
    $display("[TB] test_peak_wide done");
  endtask

  initial begin
    rst_n_b = 1'b0;
    bus_b.start = 1'b0; bus_b.sa16 = 1'b0; bus_b.sa17 = 1'b0;
    bus_b.peak_clr = 1'b0; bus_b.ADR_O = 32'h0;
    test_reset();
    test_sa16_pulse();
    test_timeout();
    test_boundary_at_timeout();
    test_back_to_back();
    test_requalify();
    test_peak_wide();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
